// File: rtl/mmio_frame_reader_pkg.sv
// ============================================================================
// mmio_frame_reader_pkg
// Shared state encoding and default bus widths for the frame reader.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mmio_frame_reader_pkg;

  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/mmio_frame_reader_fwft_fifo.sv
// ============================================================================
// fwft_fifo
// First-word-fall-through FIFO; the head entry is visible on rdata_o.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fwft_fifo
  import mmio_frame_reader_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW + 1)'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is still legal when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

`default_nettype wire

// File: rtl/mmio_frame_reader.sv
// ============================================================================
// mmio_frame_reader
// Reads a block of RAM words through a granted read port and streams them out.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mmio_frame_reader
  import mmio_frame_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] length,
  output logic                  busy,
  output logic                  done,
  input  logic                  mem_grant,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] issue_cnt_q, issue_cnt_d;
  logic [ADDR_WIDTH-1:0] out_cnt_q, out_cnt_d;
  logic                  inflight_q;
  logic                  done_q, done_d;

  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  credit_ok;
  logic                  issue;
  logic                  xfer;

  // Reserve a FIFO slot for the read still in flight so returns never overflow.
  assign credit_ok = (fifo_count + CW'(inflight_q)) < CW'(FIFO_DEPTH);
  assign issue     = (state_q == ST_FETCH) && mem_grant && (issue_cnt_q != '0)
                     && credit_ok && !fifo_full;
  assign xfer      = pix_valid && pix_ready;

  assign mem_rd    = issue;
  assign mem_addr  = issue ? rd_ptr_q : '0;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign pix_valid = !fifo_empty;
  assign pix_data  = fifo_empty ? '0 : fifo_head;

  fwft_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (inflight_q),
    .wdata_i (mem_rdata),
    .pop_i   (xfer),
    .rdata_o (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rd_ptr_q    <= '0;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      issue_cnt_q <= issue_cnt_d;
      out_cnt_q   <= out_cnt_d;
      inflight_q  <= issue;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    issue_cnt_d = issue_cnt_q;
    out_cnt_d   = xfer ? (out_cnt_q - ADDR_ONE) : out_cnt_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rd_ptr_d    = base_addr;
          issue_cnt_d = length;
          out_cnt_d   = length;
          if (length == '0) done_d  = 1'b1;
          else              state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (issue) begin
          rd_ptr_d    = rd_ptr_q + ADDR_ONE;
          issue_cnt_d = issue_cnt_q - ADDR_ONE;
          if (issue_cnt_q == ADDR_ONE) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (xfer && (out_cnt_q == ADDR_ONE)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire
